// File: rtl/stream_fifo.sv
// Parametrised single-clock valid/ready FIFO with fill level, almost-full/empty
// flags, synchronous flush and an optional registered output stage.
module stream_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int REG_OUT  = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [DATA_W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+REG_OUT):0]    level,
  output logic                              almost_full,
  output logic                              almost_empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CAP = DEPTH + REG_OUT;
  localparam int LW  = $clog2(DEPTH + REG_OUT) + 1;

  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [LW-1:0] LVL_ONE = 1;
  localparam logic [LW-1:0] LVL_CAP = LW'(CAP);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q, level_d;
  logic              af_q, ae_q;
  logic              wr_fire, rd_fire, ram_rd, ram_empty;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign wr_ready  = (level_q < LVL_CAP) & ~flush;
  assign wr_fire   = wr_valid & wr_ready;
  assign rd_fire   = rd_valid & rd_ready & ~flush;

  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

  always_comb begin
    level_d = level_q;
    if (flush)
      level_d = '0;
    else if (wr_fire && !rd_fire)
      level_d = level_q + LVL_ONE;
    else if (rd_fire && !wr_fire)
      level_d = level_q - LVL_ONE;
  end

  // Flags come from level_d so they change on the same edge as level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      af_q    <= (AF_LEVEL == 0);
      ae_q    <= 1'b1;
    end else begin
      level_q <= level_d;
      af_q    <= (32'(level_d) >= AF_LEVEL);
      ae_q    <= (32'(level_d) <= AE_LEVEL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_rd)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic              ov_q;
      logic [DATA_W-1:0] od_q;

      // Output register refills whenever it is empty or draining this cycle.
      assign ram_rd   = ~flush & ~ram_empty & (~ov_q | rd_fire);
      assign rd_valid = ov_q;
      assign rd_data  = od_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          ov_q <= 1'b0;
        else if (flush)
          ov_q <= 1'b0;
        else if (ram_rd)
          ov_q <= 1'b1;
        else if (rd_fire)
          ov_q <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (ram_rd) od_q <= mem[rd_ptr[AW-1:0]];
      end
    end else begin : g_direct
      logic rv_q;

      assign ram_rd   = rd_fire;
      assign rd_valid = rv_q;
      assign rd_data  = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          rv_q <= 1'b0;
        else
          rv_q <= (level_d != '0);
      end
    end
  endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and scoreboard checks of stream_fifo, DEPTH=4, with and without
// the registered output stage.
module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        rst;

  logic        f0, wv0, wr0, rv0, rr0, af0, ae0;
  logic [31:0] wd0, rd0;
  logic [2:0]  lvl0;

  logic        f1, wv1, wr1, rv1, rr1, af1, ae1;
  logic [31:0] wd1, rd1;
  logic [3:0]  lvl1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_W(32), .DEPTH(4), .REG_OUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(f0),
    .wr_valid(wv0), .wr_ready(wr0), .wr_data(wd0),
    .rd_valid(rv0), .rd_ready(rr0), .rd_data(rd0),
    .level(lvl0), .almost_full(af0), .almost_empty(ae0)
  );

  stream_fifo #(.DATA_W(32), .DEPTH(4), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(f1),
    .wr_valid(wv1), .wr_ready(wr1), .wr_data(wd1),
    .rd_valid(rv1), .rd_ready(rr1), .rd_data(rd1),
    .level(lvl1), .almost_full(af1), .almost_empty(ae1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sb [$];
    int          sent, rcvd, exp_l;
    bit          wf, rf;

    rst = 1'b0;
    f0 = 0; wv0 = 0; rr0 = 0; wd0 = '0;
    f1 = 0; wv1 = 0; rr1 = 0; wd1 = '0;
    #12;
    check("rst_wr_ready", 32'(wr0), 1);
    check("rst_rd_valid", 32'(rv0), 0);
    check("rst_level",    32'(lvl0), 0);
    check("rst_ae",       32'(ae0), 1);
    check("rst_af",       32'(af0), 0);
    rst = 1'b1;

    // Fill 0x11..0x44 with no reads.
    for (int i = 0; i < 4; i++) begin
      wv0 = 1; wd0 = 32'h11 * (i + 1);
      tick();
      check("fill_level", 32'(lvl0), i + 1);
      if (i == 0) begin
        check("fill_lat_valid", 32'(rv0), 1);
        check("fill_lat_data",  rd0, 32'h11);
      end
    end
    wv0 = 0;
    check("full_wr_ready", 32'(wr0), 0);
    check("full_af",       32'(af0), 1);
    check("full_ae",       32'(ae0), 0);

    rr0 = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(rv0), 1);
      check("drain_data",  rd0, 32'h11 * (i + 1));
      tick();
      if (i == 0) check("drain_wr_ready", 32'(wr0), 1);
    end
    rr0 = 0;
    check("drain_rd_valid", 32'(rv0), 0);
    check("drain_level",    32'(lvl0), 0);
    check("drain_ae",       32'(ae0), 1);

    // Steady stream at level 2, data 0..21 through a 4-deep RAM.
    for (int i = 0; i < 2; i++) begin
      wv0 = 1; wd0 = i;
      tick();
    end
    check("stream_pre_level", 32'(lvl0), 2);
    rr0 = 1;
    for (int k = 0; k < 20; k++) begin
      wd0 = k + 2;
      check("stream_valid", 32'(rv0), 1);
      check("stream_data",  rd0, k);
      tick();
      check("stream_level", 32'(lvl0), 2);
    end
    wv0 = 0;
    for (int k = 20; k < 22; k++) begin
      check("stream_tail", rd0, k);
      tick();
    end
    rr0 = 0;
    check("stream_empty", 32'(rv0), 0);

    // Flush with a concurrent write.
    for (int i = 0; i < 3; i++) begin
      wv0 = 1; wd0 = 32'hA1 + i;
      tick();
    end
    check("pre_flush_level", 32'(lvl0), 3);
    f0 = 1; wd0 = 32'hEE;
    #1;
    check("flush_wr_ready", 32'(wr0), 0);
    tick();
    f0 = 0; wv0 = 0;
    check("flush_level", 32'(lvl0), 0);
    check("flush_valid", 32'(rv0), 0);
    check("flush_ae",    32'(ae0), 1);
    tick();
    check("flush_no_store", 32'(lvl0), 0);
    wv0 = 1; wd0 = 32'hAB;
    tick();
    wv0 = 0;
    check("post_flush_valid", 32'(rv0), 1);
    check("post_flush_data",  rd0, 32'hAB);
    check("post_flush_level", 32'(lvl0), 1);
    rr0 = 1;
    tick();
    rr0 = 0;
    check("post_flush_drain", 32'(lvl0), 0);

    // Random valid/ready against a scoreboard.
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
      wv0   = (sent < 1000) && ($urandom_range(1) == 1);
      wd0   = $urandom;
      rr0   = ($urandom_range(1) == 1);
      exp_l = sb.size();
      check("rnd_wr_ready", 32'(wr0), (exp_l < 4) ? 1 : 0);
      check("rnd_rd_valid", 32'(rv0), (exp_l > 0) ? 1 : 0);
      wf = wv0 && (exp_l < 4);
      rf = rr0 && (exp_l > 0);
      if (rf) check("rnd_data", rd0, sb[0]);
      tick();
      if (rf) begin
        void'(sb.pop_front());
        rcvd++;
      end
      if (wf) begin
        sb.push_back(wd0);
        sent++;
      end
      check("rnd_level", 32'(lvl0), sb.size());
      check("rnd_af", 32'(af0), (sb.size() >= 2) ? 1 : 0);
      check("rnd_ae", 32'(ae0), (sb.size() <= 2) ? 1 : 0);
    end
    wv0 = 0; rr0 = 0;
    check("rnd_done", rcvd, 1000);

    // Registered output stage: capacity 5, two-edge latency.
    wv1 = 1; wd1 = 1;
    tick();
    check("ro_lat_valid0", 32'(rv1), 0);
    check("ro_level1",     32'(lvl1), 1);
    wd1 = 2;
    tick();
    check("ro_lat_valid1", 32'(rv1), 1);
    check("ro_first_data", rd1, 1);
    check("ro_level2",     32'(lvl1), 2);
    for (int i = 3; i <= 5; i++) begin
      wd1 = i;
      if (i == 5) check("ro_ready_at4", 32'(wr1), 1);
      tick();
    end
    wv1 = 0;
    check("ro_full_level", 32'(lvl1), 5);
    check("ro_full_ready", 32'(wr1), 0);
    check("ro_full_af",    32'(af1), 1);
    rr1 = 1;
    for (int i = 1; i <= 5; i++) begin
      check("ro_rd_valid", 32'(rv1), 1);
      check("ro_rd_data",  rd1, i);
      tick();
      if (i == 1) check("ro_ready_back", 32'(wr1), 1);
    end
    rr1 = 0;
    check("ro_empty_valid", 32'(rv1), 0);
    check("ro_empty_level", 32'(lvl1), 0);

    // Asynchronous reset mid-stream at level 3.
    for (int i = 0; i < 3; i++) begin
      wv0 = 1; wd0 = 32'hC0 + i;
      tick();
    end
    wv0 = 0;
    check("mid_pre_level", 32'(lvl0), 3);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rv0), 0);
    check("mid_rst_level", 32'(lvl0), 0);
    check("mid_rst_ready", 32'(wr0), 1);
    check("mid_rst_ae",    32'(ae0), 1);
    check("mid_rst_af",    32'(af0), 0);
    #1;
    rst = 1'b1;
    wv0 = 1; wd0 = 32'h5A;
    tick();
    wv0 = 0;
    check("mid_after_valid", 32'(rv0), 1);
    check("mid_after_data",  rd0, 32'h5A);
    check("mid_after_level", 32'(lvl0), 1);
    rr0 = 1;
    tick();
    rr0 = 0;
    check("mid_after_drain", 32'(rv0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
